// File: rtl/ctrl_fsm_pkg.sv
// Shared encodings for the copperv control FSM:
// state codes, instruction classes, mux selects and trap causes.
package ctrl_fsm_pkg;

    localparam int STATE_WIDTH       = 4;
    localparam int RD_DIN_SEL_WIDTH  = 2;
    localparam int PC_NEXT_SEL_WIDTH = 2;
    localparam int TRAP_CAUSE_WIDTH  = 2;

    localparam logic [3:0] STATE_RESET    = 4'd0;
    localparam logic [3:0] STATE_FETCH    = 4'd1;
    localparam logic [3:0] STATE_IDLE     = 4'd2;
    localparam logic [3:0] STATE_LOAD     = 4'd3;
    localparam logic [3:0] STATE_EXEC     = 4'd4;
    localparam logic [3:0] STATE_WB       = 4'd5;
    localparam logic [3:0] STATE_MEM_WAIT = 4'd6;
    localparam logic [3:0] STATE_TRAP     = 4'd7;

    localparam logic [2:0] INST_TYPE_IMM     = 3'd0;
    localparam logic [2:0] INST_TYPE_INT_IMM = 3'd1;
    localparam logic [2:0] INST_TYPE_INT_REG = 3'd2;
    localparam logic [2:0] INST_TYPE_LOAD    = 3'd3;
    localparam logic [2:0] INST_TYPE_STORE   = 3'd4;
    localparam logic [2:0] INST_TYPE_BRANCH  = 3'd5;
    localparam logic [2:0] INST_TYPE_JAL     = 3'd6;
    localparam logic [2:0] INST_TYPE_ILLEGAL = 3'd7;

    localparam logic [1:0] RD_DIN_SEL_IMM = 2'd0;
    localparam logic [1:0] RD_DIN_SEL_ALU = 2'd1;
    localparam logic [1:0] RD_DIN_SEL_MEM = 2'd2;
    localparam logic [1:0] RD_DIN_SEL_PC4 = 2'd3;

    localparam logic [1:0] PC_NEXT_SEL_STALL  = 2'd0;
    localparam logic [1:0] PC_NEXT_SEL_INCR   = 2'd1;
    localparam logic [1:0] PC_NEXT_SEL_BRANCH = 2'd2;
    localparam logic [1:0] PC_NEXT_SEL_JUMP   = 2'd3;

    localparam logic [1:0] TRAP_CAUSE_NONE         = 2'd0;
    localparam logic [1:0] TRAP_CAUSE_ILLEGAL      = 2'd1;
    localparam logic [1:0] TRAP_CAUSE_INST_TIMEOUT = 2'd2;
    localparam logic [1:0] TRAP_CAUSE_DATA_TIMEOUT = 2'd3;

endpackage

// File: rtl/ctrl_fsm_watchdog.sv
// Bus watchdog: counts enabled cycles since the last clear and
// flags expire on the LIMIT-th one. LIMIT=0 disables it.
// Ports: clk, rst (sync, active-low), clr, en, expire.
module ctrl_watchdog #(
    parameter int LIMIT = 16,
    parameter int WIDTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);
    localparam logic ACTIVE = (LIMIT != 0);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && ACTIVE) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // Fires during the last permitted waiting cycle.
    assign expire = ACTIVE && en && (cnt == LAST);

endmodule

// File: rtl/ctrl_fsm.sv
// copperv multi-cycle control FSM with data handshake, watchdog
// and sticky trap. Ports: clk, rst (sync, active-low), inst_type,
// inst_valid, data_valid, branch_taken in; datapath enables,
// mux selects, data bus request and trap status out.
module ctrl_fsm
    import ctrl_fsm_pkg::*;
#(
    parameter int INST_TYPE_WIDTH = 3,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int TIMEOUT_WIDTH   = 5,
    parameter int RESET_CYCLES    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INST_TYPE_WIDTH-1:0]   inst_type,
    input  logic                         inst_valid,
    input  logic                         data_valid,
    input  logic                         branch_taken,
    output logic                         inst_fetch,
    output logic                         rs1_en,
    output logic                         rs2_en,
    output logic                         rd_en,
    output logic [RD_DIN_SEL_WIDTH-1:0]  rd_din_sel,
    output logic [PC_NEXT_SEL_WIDTH-1:0] pc_next_sel,
    output logic                         alu_en,
    output logic                         data_req,
    output logic                         data_we,
    output logic                         trap,
    output logic [TRAP_CAUSE_WIDTH-1:0]  trap_cause
);

    localparam int RC_W =
        (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES - 1);

    logic [STATE_WIDTH-1:0]      state_q, state_d;
    logic [RC_W-1:0]             rst_cnt_q;
    logic [TRAP_CAUSE_WIDTH-1:0] cause_q, cause_d;
    logic                        wd_en, wd_clr, wd_expire;

    logic t_imm, t_int_imm, t_int_reg, t_load;
    logic t_store, t_branch, t_jal, t_illegal;

    assign t_imm     = inst_type == INST_TYPE_IMM;
    assign t_int_imm = inst_type == INST_TYPE_INT_IMM;
    assign t_int_reg = inst_type == INST_TYPE_INT_REG;
    assign t_load    = inst_type == INST_TYPE_LOAD;
    assign t_store   = inst_type == INST_TYPE_STORE;
    assign t_branch  = inst_type == INST_TYPE_BRANCH;
    assign t_jal     = inst_type == INST_TYPE_JAL;
    assign t_illegal = inst_type == INST_TYPE_ILLEGAL;

    // Any state change restarts the watchdog.
    assign wd_clr = state_d != state_q;

    ctrl_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        wd_en   = 1'b0;
        case (state_q)
            STATE_RESET: begin
                if (rst_cnt_q == RC_LAST) state_d = STATE_FETCH;
            end
            STATE_FETCH: state_d = STATE_IDLE;
            STATE_IDLE: begin
                wd_en = 1'b1;
                if (inst_valid) begin
                    state_d = STATE_LOAD;
                end else if (wd_expire) begin
                    state_d = STATE_TRAP;
                    cause_d = TRAP_CAUSE_INST_TIMEOUT;
                end
            end
            STATE_LOAD: begin
                if (t_illegal) begin
                    state_d = STATE_TRAP;
                    cause_d = TRAP_CAUSE_ILLEGAL;
                end else begin
                    state_d = STATE_EXEC;
                end
            end
            STATE_EXEC: begin
                unique case (1'b1)
                    t_int_imm, t_int_reg: state_d = STATE_WB;
                    t_load, t_store:      state_d = STATE_MEM_WAIT;
                    default:              state_d = STATE_FETCH;
                endcase
            end
            STATE_WB: state_d = STATE_FETCH;
            STATE_MEM_WAIT: begin
                wd_en = 1'b1;
                if (data_valid) begin
                    state_d = STATE_FETCH;
                end else if (wd_expire) begin
                    state_d = STATE_TRAP;
                    cause_d = TRAP_CAUSE_DATA_TIMEOUT;
                end
            end
            STATE_TRAP: state_d = STATE_TRAP;
            default:    state_d = STATE_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= STATE_RESET;
            rst_cnt_q <= '0;
            cause_q   <= TRAP_CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q != STATE_RESET) begin
                rst_cnt_q <= '0;
            end else if (rst_cnt_q != RC_LAST) begin
                rst_cnt_q <= rst_cnt_q + RC_W'(1);
            end
        end
    end

    always_comb begin
        inst_fetch  = 1'b0;
        rs1_en      = 1'b0;
        rs2_en      = 1'b0;
        rd_en       = 1'b0;
        rd_din_sel  = RD_DIN_SEL_IMM;
        pc_next_sel = PC_NEXT_SEL_STALL;
        alu_en      = 1'b0;
        data_req    = 1'b0;
        data_we     = 1'b0;
        trap        = 1'b0;
        case (state_q)
            STATE_FETCH: begin
                inst_fetch  = 1'b1;
                pc_next_sel = PC_NEXT_SEL_INCR;
            end
            STATE_LOAD: begin
                rs1_en = t_int_imm | t_int_reg | t_load
                       | t_store | t_branch;
                rs2_en = t_int_reg | t_store | t_branch;
            end
            STATE_EXEC: begin
                alu_en = !t_imm;
                unique case (1'b1)
                    t_imm: begin
                        rd_en      = 1'b1;
                        rd_din_sel = RD_DIN_SEL_IMM;
                    end
                    t_branch: begin
                        pc_next_sel = branch_taken
                            ? PC_NEXT_SEL_BRANCH
                            : PC_NEXT_SEL_STALL;
                    end
                    t_jal: begin
                        rd_en       = 1'b1;
                        rd_din_sel  = RD_DIN_SEL_PC4;
                        pc_next_sel = PC_NEXT_SEL_JUMP;
                    end
                    default: begin
                    end
                endcase
            end
            STATE_WB: begin
                rd_en      = 1'b1;
                rd_din_sel = RD_DIN_SEL_ALU;
            end
            STATE_MEM_WAIT: begin
                data_req = 1'b1;
                data_we  = t_store;
                // Load data is written back in the ack cycle.
                if (data_valid && t_load) begin
                    rd_en      = 1'b1;
                    rd_din_sel = RD_DIN_SEL_MEM;
                end
            end
            STATE_TRAP: trap = 1'b1;
            default: begin
            end
        endcase
    end

    assign trap_cause = cause_q;

endmodule
